// File: rtl/sumnb_seq.sv
// Chunk-serial adder/subtractor: one CHUNK-bit ripple slice per clock with a
// registered carry; start/done handshake, results and flags held until next DONE.
module sumnb_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] So,
  output logic             Co,
  output logic             Ov,
  output logic             Z
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_s;
  logic             carry_r;
  logic [IW-1:0]    idx_r;
  logic             accept_s;
  logic             last_s;
  logic [CHUNK-1:0] slice_s;
  logic             cout_s;
  logic             cmsb_s;

  // CHUNK-bit ripple stage on the low slice of the operand shift registers
  always_comb begin
    logic c;
    c       = carry_r;
    cmsb_s  = carry_r;
    slice_s = {CHUNK{1'b0}};
    for (int k = 0; k < CHUNK; k++) begin
      if (k == CHUNK - 1) begin
        cmsb_s = c;
      end else begin
        cmsb_s = cmsb_s;
      end
      slice_s[k] = a_r[k] ^ b_r[k] ^ c;
      c          = (a_r[k] & b_r[k]) | (c & (a_r[k] ^ b_r[k]));
    end
    cout_s = c;
  end

  // Result shifts right; the newest slice enters at the top so the last slice
  // lands in the most significant position.
  assign res_s = (res_r >> CHUNK) | (WIDTH'(slice_s) << (WIDTH - CHUNK));

  // Next-state and accept decode
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = (idx_r == IW'(NCH - 1));
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IW{1'b0}};
      So      <= {WIDTH{1'b0}};
      Co      <= 1'b0;
      Ov      <= 1'b0;
      Z       <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == RUN);
      done    <= (state_s == DONE);
      if (accept_s) begin
        // Subtraction is A + ~B + ~Ci, so the borrow-in becomes an inverted carry-in
        a_r     <= A;
        b_r     <= op ? ~B : B;
        carry_r <= op ? ~Ci : Ci;
        idx_r   <= {IW{1'b0}};
        res_r   <= {WIDTH{1'b0}};
      end else if (state_r == RUN) begin
        a_r     <= a_r >> CHUNK;
        b_r     <= b_r >> CHUNK;
        carry_r <= cout_s;
        idx_r   <= idx_r + IW'(1);
        res_r   <= res_s;
        if (last_s) begin
          So <= res_s;
          Co <= cout_s;
          Ov <= cout_s ^ cmsb_s;
          Z  <= (res_s == {WIDTH{1'b0}});
        end else begin
          So <= So;
        end
      end else begin
        idx_r <= idx_r;
      end
    end
  end

endmodule

// File: tb/tb_sumnb_seq.sv
// Scoreboard bench for sumnb_seq (WIDTH=16, CHUNK=4): directed spec cases plus
// randomized traffic checked against an integer-arithmetic reference model.
module tb_sumnb_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] A = 16'h0000;
  logic [W-1:0] B = 16'h0000;
  logic         Ci = 1'b0;
  logic         busy, done, Co, Ov, Z;
  logic [W-1:0] So;

  typedef struct {
    logic [W-1:0] so;
    logic         co;
    logic         ov;
    logic         z;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  sumnb_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B), .Ci(Ci),
    .busy(busy), .done(done), .So(So), .Co(Co), .Ov(Ov), .Z(Z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow
  function automatic exp_t model(input bit o, input bit [W-1:0] a, input bit [W-1:0] b, input bit c);
    exp_t e;
    int   u;
    int   r;
    int   sa;
    int   sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!o) begin
      u    = int'(a) + int'(b) + int'(c);
      e.co = (u > 65535);
      r    = sa + sb + int'(c);
    end else begin
      u    = int'(a) - int'(b) - int'(c);
      e.co = (int'(a) >= int'(b) + int'(c));
      r    = sa - sb - int'(c);
    end
    e.so  = u[15:0];
    e.ov  = (r > 32767) || (r < -32768);
    e.z   = (e.so == 16'h0000);
    e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk(input bit [W-1:0] so, input bit co, input bit ov, input bit z);
    exp_t e;
    e.so = so; e.co = co; e.ov = ov; e.z = z; e.acc = 0;
    return e;
  endfunction

  // Call at a negedge; waits for the block to accept, then issues one request
  task automatic issue(input bit o, input bit [W-1:0] a, input bit [W-1:0] b, input bit c,
                       input bit use_given, input exp_t given);
    exp_t e;
    int   n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", {31'd0, busy}, 32'd0);
    op = o; A = a; B = b; Ci = c; start = 1'b1;
    e = use_given ? given : model(o, a, b, c);
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", {31'd0, done}, 32'd1);
  endtask

  // Monitor: pops one expectation per done pulse and checks values and timing
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt = busy_cnt + 1;
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("So", {16'd0, So}, {16'd0, e.so});
          chk("Co", {31'd0, Co}, {31'd0, e.co});
          chk("Ov", {31'd0, Ov}, {31'd0, e.ov});
          chk("Z", {31'd0, Z}, {31'd0, e.z});
          chk("latency", cyc - e.acc, 32'd4);
          chk("busy_cycles", busy_cnt, 32'd4);
          chk("busy_in_done", {31'd0, busy}, 32'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    exp_t dummy;
    int   n;
    dummy = mk(16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {12'd0, busy, done, Co, Ov, Z, So}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b1, mk(16'h5555, 1'b0, 1'b0, 1'b0));
    wait_done();
    repeat (2) @(negedge clk);
    issue(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1));
    issue(1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b0));
    issue(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0));
    issue(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
    wait_done();
    @(negedge clk);

    // start and operand changes during RUN are ignored
    issue(1'b0, 16'h0010, 16'h0020, 1'b0, 1'b1, mk(16'h0030, 1'b0, 1'b0, 1'b0));
    A = 16'h0001; B = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // back-to-back accept in the DONE cycle
    issue(1'b0, 16'h00FF, 16'h0F01, 1'b0, 1'b1, mk(16'h1000, 1'b0, 1'b0, 1'b0));
    wait_done();
    issue(1'b1, 16'h0100, 16'h0001, 1'b1, 1'b1, mk(16'h00FE, 1'b1, 1'b0, 1'b0));
    wait_done();
    repeat (2) @(negedge clk);

    // reset after two RUN edges aborts the operation
    issue(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b1, mk(16'h2345, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_run", {12'd0, busy, done, Co, Ov, Z, So}, 32'd0);
    void'(q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_done_after_abort", {31'd0, done}, 32'd0);
    issue(1'b0, 16'h0002, 16'h0003, 1'b0, 1'b1, mk(16'h0005, 1'b0, 1'b0, 1'b0));
    wait_done();
    @(negedge clk);

    // randomized traffic with occasional ignored starts and idle gaps
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            1'b0, dummy);
      if ($urandom_range(0, 2) == 0) begin
        A = 16'($urandom); B = 16'($urandom); op = ~op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        wait_done();
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
